// File: rtl/data_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Byte lanes are big-endian: byte offset 0 is word bits [31:24].
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } state_t;

    function automatic int tag_width(input int address_width, input int set_width);
        return address_width - set_width - 2;
    endfunction

    function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] offset);
        logic [7:0] lane;
        case (offset)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

    // Bit 3 of the enable covers [31:24], so offset k maps to bit 3-k.
    function automatic logic [3:0] byte_enable(input logic byte_op, input logic [1:0] offset);
        return byte_op ? (4'b1000 >> offset) : 4'hF;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read, one byte-masked write port,
// synchronous clear of every valid bit.
module cache_line_store #(
    parameter int SET_WIDTH  = 8,
    parameter int TAG_WIDTH  = 22,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic [SET_WIDTH-1:0]  i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_WIDTH-1:0]  o_rd_tag,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [SET_WIDTH-1:0]  i_wr_index,
    input  logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [3:0]            i_wr_mask
);

    localparam int LINES = 1 << SET_WIDTH;

    logic [LINES-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; a line is only ever trusted through
    // its valid bit, so resetting the bulk storage would cost flops for nothing.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index] <= i_wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[i_wr_index][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a registered
// request/acknowledge memory port; misses, writes and flushes stall the CPU.
module data_cache import data_cache_pkg::*; #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     we,
    input  logic                     ByteOp,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int TAG_WIDTH = tag_width(ADDRESS_WIDTH, SET_WIDTH);

    state_t r_state, w_next;

    logic                     r_mem_req, r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [3:0]               r_mem_be;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;

    logic [SET_WIDTH-1:0]  w_index;
    logic [TAG_WIDTH-1:0]  w_tag, w_rd_tag;
    logic [1:0]            w_offset;
    logic                  w_rd_valid, w_hit, w_launch;
    logic [DATA_WIDTH-1:0] w_rd_data, w_wr_data, w_store_data;
    logic [3:0]            w_wr_mask;
    logic                  w_wr_en, w_clear;

    assign w_index      = Address[SET_WIDTH+1:2];
    assign w_tag        = Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign w_offset     = Address[1:0];
    assign w_hit        = w_rd_valid && (w_rd_tag == w_tag);
    assign w_store_data = ByteOp ? {4{WriteData[7:0]}} : WriteData;
    assign w_launch     = (r_state == IDLE) && ((w_next == FILL) || (w_next == WRITE));

    function automatic logic [DATA_WIDTH-1:0] format_read(input logic [DATA_WIDTH-1:0] word);
        return ByteOp ? {{(DATA_WIDTH-8){1'b0}}, lane_select(word, w_offset)} : word;
    endfunction

    cache_line_store #(
        .SET_WIDTH  (SET_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_wr_data),
        .i_wr_mask  (w_wr_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        ReadData  = '0;
        w_wr_en   = 1'b0;
        w_wr_data = mem_rdata;
        w_wr_mask = 4'hF;
        w_clear   = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_next = FLUSH;
                    stall  = cpu_req;
                end else if (cpu_req) begin
                    if (we) begin
                        w_next = WRITE;
                        stall  = 1'b1;
                    end else if (w_hit) begin
                        ReadData = format_read(w_rd_data);
                    end else begin
                        w_next = FILL;
                        stall  = 1'b1;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    stall    = 1'b0;
                    w_wr_en  = 1'b1;
                    ReadData = format_read(mem_rdata);
                    w_next   = IDLE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ack) begin
                    stall     = 1'b0;
                    w_wr_en   = w_hit;
                    w_wr_data = r_mem_wdata;
                    w_wr_mask = r_mem_be;
                    w_next    = IDLE;
                end
            end
            FLUSH: begin
                stall   = cpu_req;
                w_clear = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            stall    = 1'b0;
            ReadData = '0;
            w_wr_en  = 1'b0;
        end
    end

    // Memory-port registers stay frozen from launch until the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else if (w_launch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= we;
            r_mem_addr  <= {Address[ADDRESS_WIDTH-1:2], 2'b00};
            r_mem_be    <= we ? byte_enable(ByteOp, w_offset) : 4'hF;
            r_mem_wdata <= we ? w_store_data : '0;
        end else if (r_mem_req && mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache: the reference treats the cache as
// "loads return current memory contents" plus a per-index resident word map.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst, cpu_req, we, ByteOp, flush, mem_ack;
    logic [31:0] Address, WriteData, mem_rdata;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    data_cache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .we        (we),
        .ByteOp    (ByteOp),
        .Address   (Address),
        .WriteData (WriteData),
        .flush     (flush),
        .ReadData  (ReadData),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        is_write;
        logic [31:0] data;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    logic [31:0] ref_mem   [int unsigned];
    logic [31:0] mem_store [int unsigned];
    int unsigned resident  [int unsigned];

    function automatic logic [31:0] default_word(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : default_word(wa);
    endfunction

    function automatic logic [31:0] store_read(input int unsigned wa);
        return mem_store.exists(wa) ? mem_store[wa] : default_word(wa);
    endfunction

    // Memory responder: checks each new transaction against the expected queue
    // and acks after a delay of 1..4 cycles (or fixed_delay when set).
    bit          resp_en     = 1'b1;
    int          fixed_delay = 0;
    int          wait_cnt    = -1;
    logic [31:0] cap_addr;

    initial begin
        mem_exp_t    e;
        int unsigned wa;
        logic [31:0] w;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!resp_en) begin
                wait_cnt = -1;
            end else if (mem_req) begin
                if (wait_cnt < 0) begin
                    if (mem_q.size() == 0) begin
                        check("mem_req_unexpected", {31'b0, mem_req}, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_be", {28'b0, mem_be}, {28'b0, e.be});
                        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                    end
                    cap_addr = mem_addr;
                    wait_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
                end
                wait_cnt--;
                if (wait_cnt == 0) begin
                    check("mem_addr_stable", mem_addr, cap_addr);
                    wa = mem_addr >> 2;
                    if (mem_we) begin
                        w = store_read(wa);
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_store[wa] = w;
                    end else begin
                        mem_rdata = store_read(wa);
                    end
                    mem_ack  = 1'b1;
                    wait_cnt = -1;
                end
            end
        end
    end

    // Monitor: every completed CPU access pops one expectation.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cpu_req && !stall) begin
                if (cpu_q.size() == 0) begin
                    check("completion_unexpected", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    check("completion_kind", {31'b0, we}, {31'b0, e.is_write});
                    if (!e.is_write) check("read_data", ReadData, e.data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic access(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, input bit flush_mid);
        int unsigned wa  = a >> 2;
        int unsigned idx = wa % 256;
        int          sh  = 8 * (3 - int'(a[1:0]));
        logic [31:0] cur = ref_read(wa);
        logic [31:0] msk = 32'hFF << sh;
        logic [31:0] r   = $urandom;
        bit          hit = resident.exists(idx) && (resident[idx] == wa);
        mem_exp_t    m;
        cpu_exp_t    c;
        int          cyc = 0;
        m.addr = wa << 2;
        if (w) begin
            m.we    = 1'b1;
            m.be    = b ? 4'(1 << (3 - int'(a[1:0]))) : 4'hF;
            m.wdata = b ? {4{d[7:0]}} : d;
            ref_mem[wa] = b ? ((cur & ~msk) | ((d & 32'hFF) << sh)) : d;
            mem_q.push_back(m);
            c.is_write = 1'b1;
            c.data     = '0;
        end else begin
            c.is_write = 1'b0;
            c.data     = b ? ((cur >> sh) & 32'hFF) : cur;
            if (!hit) begin
                m.we    = 1'b0;
                m.be    = 4'hF;
                m.wdata = '0;
                mem_q.push_back(m);
                resident[idx] = wa;
            end
        end
        cpu_q.push_back(c);
        cpu_req   = 1'b1;
        we        = w;
        ByteOp    = b;
        Address   = a;
        WriteData = b ? {r[31:8], d[7:0]} : d;
        @(negedge clk);
        if (!w && hit) check("hit_no_stall", {31'b0, stall}, 32'd0);
        else           check("miss_stall", {31'b0, stall}, 32'd1);
        while (stall && cyc < 40) begin
            @(posedge clk);
            #1;
            if (flush_mid) flush = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) check("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        we      = 1'b0;
        ByteOp  = 1'b0;
        if (flush_mid) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            flush = 1'b0;
            resident.delete();
        end
    endtask

    task automatic do_flush();
        flush   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("flush_idle_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b0;
        resident.delete();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        check({tag, "_rdata"}, ReadData, 32'd0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;
        rst = 1'b1; cpu_req = 1'b0; we = 1'b0; ByteOp = 1'b0;
        Address = '0; WriteData = '0; flush = 1'b0;
        mem_store[32'h10000 >> 2] = 32'h11223344;
        ref_mem[32'h10000 >> 2]   = 32'h11223344;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;

        fixed_delay = 2;
        access(1'b0, 1'b0, 32'h10000, '0, 1'b0);
        fixed_delay = 0;
        access(1'b0, 1'b0, 32'h10000, '0, 1'b0);
        for (int k = 0; k < 4; k++) access(1'b0, 1'b1, 32'h10000 + k, '0, 1'b0);
        access(1'b1, 1'b1, 32'h10002, 32'h000000AB, 1'b0);
        access(1'b0, 1'b0, 32'h10000, '0, 1'b0);
        access(1'b1, 1'b0, 32'h20000, 32'hCAFEF00D, 1'b0);
        access(1'b0, 1'b0, 32'h20000, '0, 1'b0);
        access(1'b0, 1'b0, 32'h10000, '0, 1'b0);
        access(1'b0, 1'b0, 32'h10400, '0, 1'b0);
        access(1'b0, 1'b0, 32'h10000, '0, 1'b0);
        check_idle("idle");

        access(1'b0, 1'b0, 32'h10800, '0, 1'b1);
        access(1'b0, 1'b0, 32'h10800, '0, 1'b0);
        do_flush();
        access(1'b0, 1'b1, 32'h10003, '0, 1'b0);

        // Reset during a write: port drops and a late ack is ignored.
        resp_en   = 1'b0;
        cpu_req   = 1'b1;
        we        = 1'b1;
        Address   = 32'h30000;
        WriteData = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        check("rstw_mem_req_up", {31'b0, mem_req}, 32'd1);
        check("rstw_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1; cpu_req = 1'b0; we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_mem_req_drop", {31'b0, mem_req}, 32'd0);
        @(posedge clk);
        #3 mem_ack = 1'b1;
        @(negedge clk);
        check("late_ack_stall", {31'b0, stall}, 32'd0);
        check("late_ack_rdata", ReadData, 32'd0);
        @(posedge clk);
        #3 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
        resident.delete();
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 1'b0, 32'h30000, '0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            a  = 32'h10000 | (32'($urandom_range(0, 3)) << 10)
                           | (32'($urandom_range(0, 7)) << 2)
                           | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 99);
            if (op < 8)       do_flush();
            else if (op < 45) access(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            else              access(1'b0, 1'($urandom_range(0, 1)), a, '0, 1'b0);
        end

        check_idle("final");
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and byte-addressed main memory. Replaces the fixed-latency, cacheless data memory path with a parametrised set count and a request/acknowledge memory port. Stalls the pipeline on misses and writes. Keeps the CPU-side word/byte semantics: big-endian byte order within a word, and byte reads zero-extended.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; only 32 is supported.
- SET_WIDTH, 8, log2 of the line count; one word per line.
- TAG_WIDTH, ADDRESS_WIDTH-SET_WIDTH-2, derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  access valid this cycle; held until stall is low.
- we  in  1  write access.
- ByteOp  in  1  byte access; otherwise word access (Address[1:0] ignored).
- Address  in  ADDRESS_WIDTH  byte address.
- WriteData  in  DATA_WIDTH  store data; a byte store uses [7:0].
- flush  in  1  invalidate all lines.
- ReadData  out  DATA_WIDTH  load data; valid when cpu_req && !we && !stall.
- stall  out  1  access not complete; the CPU must hold its inputs.
- mem_req  out  1  memory transaction pending.
- mem_we  out  1  transaction is a write.
- mem_addr  out  ADDRESS_WIDTH  word-aligned address, {Address[31:2],2'b0}.
- mem_be  out  4  byte enables; bit3 selects [31:24], which is byte offset 0.
- mem_wdata  out  DATA_WIDTH  write data; a byte store is replicated into all four lanes.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid with it.
- mem_rdata  in  DATA_WIDTH  word read from memory.

## Operation
- Index is Address[SET_WIDTH+1:2]. Tag is Address[ADDRESS_WIDTH-1:SET_WIDTH+2]. A hit requires valid && tag match.
- Lookup is combinational from registered arrays, so a read hit completes in the request cycle.
- Byte lane: offset k maps to word bits [31-8k -: 8]. A byte read returns {24'b0, lane}.
- FSM states:
  - IDLE → FILL on a read miss.
  - IDLE → WRITE on any write.
  - IDLE → FLUSH when flush is high.
  - FILL → IDLE on mem_ack.
  - WRITE → IDLE on mem_ack.
  - FLUSH → IDLE after one cycle.
- FILL:
  - mem_req=1, mem_we=0, mem_be=4'hF.
  - On mem_ack, write the line {valid=1, tag, mem_rdata}.
  - In the same cycle, drive ReadData from mem_rdata (lane-selected) with stall=0.
- WRITE:
  - mem_req=1, mem_we=1, mem_be=4'hF for a word or the one-hot lane for a byte.
  - On mem_ack, if the line hits, merge the written bytes into the cached word.
  - A write miss never allocates. stall=0 in the ack cycle.
- FLUSH: all valid bits clear at the edge. Then return to IDLE with the request, if any, still stalled.
- flush has priority over cpu_req only in IDLE. flush in FILL/WRITE is held off until IDLE; the caller keeps it high.
- With cpu_req=0 in IDLE: stall=0, mem_req=0, ReadData=0.

## Timing
- Reset values:
  - state IDLE; all valid bits 0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - stall=0, ReadData=0.
- Reset mid-FILL or mid-WRITE drops mem_req the next cycle. A later mem_ack is ignored in IDLE.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered. They stay stable from assertion until the ack cycle, and mem_req deasserts on the edge after mem_ack.
- Read hit: 0 stall cycles.
- Read miss or write: stall=1 from the request cycle through N-1 cycles, where the ack arrives N cycles after mem_req rises. Completion is in the ack cycle.
- A back-to-back request in the cycle after completion is a fresh lookup. For example, a load immediately after a fill to the same address hits.
- A mem_ack seen while mem_req=0 is ignored.

## Structure
- data_cache_pkg holds:
  - the state_t enum {IDLE, FILL, WRITE, FLUSH};
  - the lane-select and byte-enable functions;
  - the TAG_WIDTH derivation.
- Sub-module cache_line_store holds the valid/tag/data arrays:
  - combinational read port;
  - one write port with byte mask;
  - synchronous clear-all.
- data_cache holds the FSM and the memory-port registers.

## Test plan
- Reset, then word read 0x10000 (memory returns 0x11223344 two cycles after mem_req) → stall for 2 cycles, ReadData=0x11223344 in the ack cycle. A repeat read hits with stall=0 and no mem_req.
- After that fill, byte reads 0x10000..0x10003 → 0x11, 0x22, 0x33, 0x44, each a hit.
- Byte write 0xAB to 0x10002 → mem_be=4'b0010, mem_wdata=0xABABABAB. After the ack, a word read hits with 0x1122AB44.
- Word write to uncached 0x20000 → memory write, no allocate. A following read of 0x20000 misses and issues mem_req.
- Read 0x10000, then 0x10400 (same index when SET_WIDTH=8) → second is a miss and evicts the first. Reading 0x10000 again misses.
- flush raised during FILL → fill completes, FLUSH follows, and the next read of the filled address misses. Separately, rst during WRITE → mem_req=0 the next cycle and a late ack is ignored.
